muladd_cont: RTL and testbench
==============================

# muladd_cont

Sequencing controller for the fused multiply-add instruction (rd = rs1 × rs2 + rs3). It accepts one decoded MULADD instruction at a time and runs it in two phases: a multiply into a scratch register, then an add into rd. It drives the MULADD inputs of the rs1/rs2 operand-address muxes plus the destination address, and handshakes with the multiply and add execution units. It sits directly upstream of the rs1/rs2 operand-address muxes, feeding their MULADD leg.

## Interface
- TMP_REG, 5'd31: scratch register that holds the product between the two phases.
- TIMEOUT, 16: maximum cycles spent in one wait state before abort. Used only when MULADD_TIMEOUT_EN is defined.
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  instruction valid.
- ready  out  1  block can accept; high in IDLE only.
- rs1_in, rs2_in, rs3_in, rd_in  in  5 each  instruction register fields.
- rs1_muladd_cont  out  5  rs1 address to the rs1 operand mux.
- rs2_muladd_cont  out  5  rs2 address to the rs2 operand mux.
- rd_muladd_cont  out  5  writeback address.
- muladd_active  out  1  high whenever not in IDLE; the arbiter uses it to set rs1_sel/rs2_sel to MULADD.
- mult_req, add_req  out  1 each  one-cycle issue pulses.
- mult_done, add_done  in  1 each  unit completion pulses.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle abort pulse.

## Operation
- States: IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE, ERR.
- IDLE:
  - ready=1.
  - start=1 latches rs1/rs2/rs3/rd into internal registers.
  - Hazard check: if rs3_in==TMP_REG or rd_in==TMP_REG, go to ERR with nothing issued. Otherwise go to MUL_ISSUE.
  - start=0 keeps the block in IDLE.
- MUL_ISSUE:
  - mult_req=1; rs1_muladd_cont=rs1, rs2_muladd_cont=rs2, rd_muladd_cont=TMP_REG.
  - Next state is ADD_ISSUE if mult_done=1 in this cycle, else MUL_WAIT.
- MUL_WAIT: same addresses held. mult_done=1 goes to ADD_ISSUE.
- ADD_ISSUE:
  - add_req=1; rs1_muladd_cont=TMP_REG, rs2_muladd_cont=rs3, rd_muladd_cont=rd.
  - Next state is DONE if add_done=1 in this cycle, else ADD_WAIT.
- ADD_WAIT: same addresses held. add_done=1 goes to DONE.
- DONE: done=1, then IDLE.
- ERR: err=1, then IDLE.
- Stray done pulses:
  - In IDLE, DONE or ERR, mult_done and add_done are ignored.
  - mult_done during ADD_ISSUE/ADD_WAIT is ignored.
  - add_done during MUL_ISSUE/MUL_WAIT is ignored.
- start while ready=0 is ignored; the upstream stage must hold the instruction until ready is high.
- Address outputs, registered: in IDLE, DONE and ERR they hold the last driven value. After reset that value is 0.

## Timing
- Reset: asynchronous; takes effect immediately even mid-operation. State=IDLE; all address outputs 0; mult_req, add_req, done, err, muladd_active all 0; ready=1.
- Accept occurs on the edge where start&&ready.
- Minimum latency, with each unit's done arriving in its issue cycle:
  - accept at edge 0;
  - MUL_ISSUE in cycle 1;
  - ADD_ISSUE in cycle 2;
  - done in cycle 3;
  - ready in cycle 4.
- Minimum throughput is one instruction per 4 cycles.
- Addresses are valid in the issue cycle and stay stable until the corresponding done is sampled.
- mult_req and add_req are exactly one cycle wide per phase. They are never re-asserted while waiting.

## Configuration
- Macro: MULADD_TIMEOUT_EN.
- Defined:
  - A 5-bit wait counter clears on entry to MUL_ISSUE and to ADD_ISSUE, and increments every cycle in the issue and wait states of that phase.
  - If the counter reaches TIMEOUT with no done seen, the block goes to ERR (err pulse, then IDLE).
  - A done arriving in the same cycle as the limit is reached wins; no abort.
- Undefined: no counter; the wait states wait indefinitely. err comes only from the hazard check.

## Structure
- Package muladd_pkg holds:
  - state enum;
  - operand-select codes ADD=2'b00, MULT=2'b01, MULADD=2'b10, shared with the operand muxes and arbiter;
  - default TMP_REG.
- No sub-module is needed. The optional wait counter is a small instance, timeout_cnt, compiled under the macro.

## Test plan
- Basic: start with rs1=1, rs2=2, rs3=3, rd=4; done pulses return immediately.
  - Cycle 1: mult_req=1, addresses 1/2/31.
  - Cycle 2: add_req=1, addresses 31/3/4.
  - Cycle 3: done=1.
  - Cycle 4: ready=1.
- Delayed units: mult_done 5 cycles after mult_req → addresses 1/2/31 held throughout, single mult_req; add phase follows the next cycle.
- Hazard: rd_in=31 → err=1 one cycle after accept; no mult_req or add_req; ready the following cycle.
- Back-to-back: start held high with a second instruction → the second is accepted only in the cycle after done; the start pulse during busy is dropped.
- Reset mid-operation: rst_n low during MUL_WAIT → immediately state IDLE, addresses 0, muladd_active=0. A later mult_done produces no add_req.
- MULADD_TIMEOUT_EN defined, TIMEOUT=16, mult_done never arrives → err=1 after 16 cycles of the multiply phase. A mult_done arriving on the limit cycle gives add_req instead of err.

Source files
------------

// File: rtl/muladd_pkg.sv
// muladd_pkg: shared definitions for the fused multiply-add sequencer.
//   - state_t      : controller state encoding
//   - SEL_*        : operand-select codes shared with the operand muxes/arbiter
//   - TMP_REG      : scratch register holding the product between phases
//   - TIMEOUT      : per-phase cycle limit (only used with MULADD_TIMEOUT_EN)
//   - is_hazard()  : true when an instruction would clobber or read the scratch
package muladd_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ISSUE = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  localparam logic [1:0] SEL_ADD    = 2'b00;
  localparam logic [1:0] SEL_MULT   = 2'b01;
  localparam logic [1:0] SEL_MULADD = 2'b10;

  localparam logic [4:0] TMP_REG = 5'd31;

  localparam int unsigned TIMEOUT = 16;
  // Counter value seen in the last permitted cycle of a phase (counter is 0
  // in the issue cycle, so the TIMEOUT-th phase cycle shows TIMEOUT-1).
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

  // rs3 is read in the add phase after the product is written to TMP_REG,
  // and rd==TMP_REG would make the result ambiguous; both are rejected.
  function automatic logic is_hazard(input logic [4:0] rs3, input logic [4:0] rd);
    return (rs3 == TMP_REG) || (rd == TMP_REG);
  endfunction

endpackage

// File: rtl/muladd_cont_timeout_cnt.sv
// muladd_timeout_cnt: 5-bit per-phase wait counter, only built when
// MULADD_TIMEOUT_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clr        : load zero (entry into an issue state)
//   inc        : count one cycle spent in the current phase
//   cnt        : current count (registered)
`ifdef MULADD_TIMEOUT_EN
module muladd_timeout_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [4:0] cnt
);

  logic [4:0] cnt_d;
  logic [4:0] cnt_q;

  // Next count: clear has priority, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 5'd0;
    end else if (inc && (cnt_q != 5'd31)) begin
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/muladd_cont.sv
// muladd_cont: sequencing controller for rd = rs1 * rs2 + rs3.
// Runs a multiply into TMP_REG, then an add of TMP_REG + rs3 into rd, and
// drives the MULADD leg of the rs1/rs2 operand-address muxes.
// Optional feature macro: MULADD_TIMEOUT_EN (per-phase wait timeout -> err).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start / ready                  instruction handshake (ready only in IDLE)
//   rs1_in, rs2_in, rs3_in, rd_in  instruction fields
//   rs1/rs2/rd_muladd_cont         registered operand/writeback addresses
//   muladd_active                  high whenever not IDLE
//   mult_req/add_req               one-cycle unit issue pulses
//   mult_done/add_done             unit completion pulses
//   done / err                     one-cycle completion / abort pulses
// All outputs are registered: they are computed from the next state.
module muladd_cont
  import muladd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       ready,
  input  logic [4:0] rs1_in,
  input  logic [4:0] rs2_in,
  input  logic [4:0] rs3_in,
  input  logic [4:0] rd_in,
  output logic [4:0] rs1_muladd_cont,
  output logic [4:0] rs2_muladd_cont,
  output logic [4:0] rd_muladd_cont,
  output logic       muladd_active,
  output logic       mult_req,
  output logic       add_req,
  input  logic       mult_done,
  input  logic       add_done,
  output logic       done,
  output logic       err
);

  state_t     state_q, state_d;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rd_q, rd_d;
  logic [4:0] a1_q, a1_d, a2_q, a2_d, ad_q, ad_d;
  logic       ready_q, ready_d, active_q, active_d;
  logic       mreq_q, mreq_d, areq_q, areq_d, done_q, done_d, err_q, err_d;
  logic       accept_s;
  logic       timeout_hit_s;

  assign accept_s = (state_q == S_IDLE) && start;

`ifdef MULADD_TIMEOUT_EN
  logic [4:0] wait_cnt_s;
  logic       cnt_clr_s;
  logic       cnt_inc_s;
  logic       in_phase_s;

  assign in_phase_s    = (state_q == S_MUL_ISSUE) || (state_q == S_MUL_WAIT) ||
                         (state_q == S_ADD_ISSUE) || (state_q == S_ADD_WAIT);
  assign cnt_clr_s     = (state_d == S_MUL_ISSUE) || (state_d == S_ADD_ISSUE);
  assign cnt_inc_s     = in_phase_s;
  // Abort after TIMEOUT phase cycles; a done in that cycle is checked first
  // in the next-state logic and therefore wins.
  assign timeout_hit_s = in_phase_s && (wait_cnt_s == TIMEOUT_LAST);

  muladd_timeout_cnt timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .cnt   (wait_cnt_s)
  );
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Instruction field latch: capture on accept, hold otherwise.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rs3_d = rs3_q;
    rd_d  = rd_q;
    if (accept_s) begin
      rs1_d = rs1_in;
      rs2_d = rs2_in;
      rs3_d = rs3_in;
      rd_d  = rd_in;
    end else begin
      rs1_d = rs1_q;
      rs2_d = rs2_q;
      rs3_d = rs3_q;
      rd_d  = rd_q;
    end
  end

  // Next-state logic; stray done pulses are ignored by simply not testing them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_hazard(rs3_in, rd_in) ? S_ERR : S_MUL_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_ISSUE, S_MUL_WAIT: begin
        if (mult_done) begin
          state_d = S_ADD_ISSUE;
        end else if (timeout_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_MUL_WAIT;
        end
      end
      S_ADD_ISSUE, S_ADD_WAIT: begin
        if (add_done) begin
          state_d = S_DONE;
        end else if (timeout_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_ADD_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    a1_d     = a1_q;
    a2_d     = a2_q;
    ad_d     = ad_q;
    ready_d  = (state_d == S_IDLE);
    active_d = (state_d != S_IDLE);
    mreq_d   = (state_d == S_MUL_ISSUE);
    areq_d   = (state_d == S_ADD_ISSUE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
    case (state_d)
      S_MUL_ISSUE, S_MUL_WAIT: begin
        a1_d = rs1_d;
        a2_d = rs2_d;
        ad_d = TMP_REG;
      end
      S_ADD_ISSUE, S_ADD_WAIT: begin
        a1_d = TMP_REG;
        a2_d = rs3_d;
        ad_d = rd_d;
      end
      default: begin
        // IDLE, DONE and ERR keep the last driven addresses.
        a1_d = a1_q;
        a2_d = a2_q;
        ad_d = ad_q;
      end
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rs3_q    <= 5'd0;
      rd_q     <= 5'd0;
      a1_q     <= 5'd0;
      a2_q     <= 5'd0;
      ad_q     <= 5'd0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      mreq_q   <= 1'b0;
      areq_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs3_q    <= rs3_d;
      rd_q     <= rd_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      ad_q     <= ad_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      mreq_q   <= mreq_d;
      areq_q   <= areq_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready           = ready_q;
  assign muladd_active   = active_q;
  assign mult_req        = mreq_q;
  assign add_req         = areq_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rs1_muladd_cont = a1_q;
  assign rs2_muladd_cont = a2_q;
  assign rd_muladd_cont  = ad_q;

endmodule

// File: tb/tb_muladd_cont.sv
// tb_muladd_cont: directed self-checking bench for muladd_cont.
// Observed vector layout: {ready, active, mult_req, add_req, done, err, rs1, rs2, rd}.
module tb_muladd_cont;

  localparam logic [4:0] T = 5'd31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] rs1_in = 5'd0, rs2_in = 5'd0, rs3_in = 5'd0, rd_in = 5'd0;
  logic       mult_done = 1'b0, add_done = 1'b0;
  logic       ready, muladd_active, mult_req, add_req, done, err;
  logic [4:0] rs1_muladd_cont, rs2_muladd_cont, rd_muladd_cont;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_v;
  logic [20:0] obs;

  assign obs = {ready, muladd_active, mult_req, add_req, done, err,
                rs1_muladd_cont, rs2_muladd_cont, rd_muladd_cont};

  always #5 clk = ~clk;

  muladd_cont dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rs3_in(rs3_in), .rd_in(rd_in),
    .rs1_muladd_cont(rs1_muladd_cont), .rs2_muladd_cont(rs2_muladd_cont),
    .rd_muladd_cont(rd_muladd_cont), .muladd_active(muladd_active),
    .mult_req(mult_req), .add_req(add_req),
    .mult_done(mult_done), .add_done(add_done),
    .done(done), .err(err)
  );

  task automatic set_instr(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] d);
    rs1_in = a; rs2_in = b; rs3_in = c; rd_in = d;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_state got %h expected %h", obs, exp_v); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_basic();
    set_instr(5'd1, 5'd2, 5'd3, 5'd4);
    start = 1'b1;
    @(negedge clk); // cycle 1
    start = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_c1 got %h expected %h", obs, exp_v); end
    mult_done = 1'b1;
    @(negedge clk); // cycle 2
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_c2 got %h expected %h", obs, exp_v); end
    add_done = 1'b1;
    @(negedge clk); // cycle 3
    add_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_c3 got %h expected %h", obs, exp_v); end
    @(negedge clk); // cycle 4
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_c4 got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_delayed();
    set_instr(5'd5, 5'd6, 5'd7, 5'd8);
    start = 1'b1;
    @(negedge clk); // cycle 1: MUL_ISSUE
    start = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL delay_issue got %h expected %h", obs, exp_v); end
    // cycles 2..6 waiting; stray add_done in cycle 3; mult_done in cycle 6
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      add_done  = (i == 3);
      mult_done = (i == 6);
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, T};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL delay_mwait_c%0d got %h expected %h", i, obs, exp_v); end
    end
    @(negedge clk); // cycle 7: ADD_ISSUE
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL delay_add_issue got %h expected %h", obs, exp_v); end
    mult_done = 1'b1; // stray, must be ignored
    @(negedge clk); // cycle 8: ADD_WAIT
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL delay_add_wait got %h expected %h", obs, exp_v); end
    add_done = 1'b1;
    @(negedge clk); // cycle 9: DONE
    add_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL delay_done got %h expected %h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    // rd hits the scratch register
    set_instr(5'd1, 5'd2, 5'd3, T);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_rd_err got %h expected %h", obs, exp_v); end
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_rd_ready got %h expected %h", obs, exp_v); end
    // rs3 hits the scratch register
    set_instr(5'd1, 5'd2, T, 5'd9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, T, 5'd7, 5'd8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_rs3_err got %h expected %h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_instr(5'd1, 5'd2, 5'd3, 5'd4);
    start = 1'b1;
    @(negedge clk); // cycle 1, start stays high with new instruction
    set_instr(5'd9, 5'd10, 5'd11, 5'd12);
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_a_mul got %h expected %h", obs, exp_v); end
    mult_done = 1'b1;
    @(negedge clk); // cycle 2
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_a_add got %h expected %h", obs, exp_v); end
    add_done = 1'b1;
    @(negedge clk); // cycle 3
    add_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_a_done got %h expected %h", obs, exp_v); end
    @(negedge clk); // cycle 4: IDLE, B accepted on the following edge
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_idle got %h expected %h", obs, exp_v); end
    @(negedge clk); // cycle 5
    start = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd10, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_b_mul got %h expected %h", obs, exp_v); end
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 5'd11, 5'd12};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_b_add got %h expected %h", obs, exp_v); end
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_instr(5'd1, 5'd2, 5'd3, 5'd4);
    start = 1'b1;
    @(negedge clk); // MUL_ISSUE
    start = 1'b0;
    @(negedge clk); // MUL_WAIT
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_wait got %h expected %h", obs, exp_v); end
    rst_n = 1'b0;
    #1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_async got %h expected %h", obs, exp_v); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_no_add got %h expected %h", obs, exp_v); end
  endtask

`ifdef MULADD_TIMEOUT_EN
  task automatic test_timeout();
    set_instr(5'd1, 5'd2, 5'd3, 5'd4);
    start = 1'b1;
    @(negedge clk); // phase cycle 1
    start = 1'b0;
    for (int i = 2; i <= 16; i++) @(negedge clk);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_c16 got %h expected %h", obs, exp_v); end
    @(negedge clk); // cycle 17
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, T};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_err got %h expected %h", obs, exp_v); end
    @(negedge clk);
    // done on the limit cycle wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 16; i++) @(negedge clk);
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 5'd3, 5'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_limit_done got %h expected %h", obs, exp_v); end
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delayed();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
`ifdef MULADD_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
